clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Timekeeping datapath driven by the clock-mode state machine's command outputs (sec_reset, min_inc, hour_inc, *_onoff).
- Holds hours, minutes and seconds in BCD, advances them on a 1 Hz enable, and applies the manual set commands.
- Produces per-field blanking strobes so the display blinks the field currently selected for setting.

Parameters:
- MODE24, 1, 1 = 24-hour (00..23); 0 = 12-hour (01..12)

Ports:
- ck  input  1  system clock
- sysreset  input  1  asynchronous active-high reset
- en1hz  input  1  one-ck-wide pulse, once per second
- blink  input  1  display blink phase; 1 = visible half-period
- sec_reset  input  1  level; hold seconds at 00 while high
- min_inc  input  1  level (switch-derived); each rising edge adds one minute
- hour_inc  input  1  level (switch-derived); each rising edge adds one hour
- sec_onoff  input  1  seconds field selected for setting
- min_onoff  input  1  minutes field selected for setting
- hour_onoff  input  1  hours field selected for setting
- sec  output  8  BCD seconds {tens[3:0], ones[3:0]}, 00..59
- min  output  8  BCD minutes, 00..59
- hour  output  8  BCD hours, 00..23 or 01..12
- sec_blank  output  1  1 = blank the seconds digits
- min_blank  output  1  1 = blank the minutes digits
- hour_blank  output  1  1 = blank the hours digits

Behaviour:
- Reset: one clock, ck; reset is sysreset, asynchronous and active-high. On reset: sec = 8'h00, min = 8'h00, hour = 8'h00 (MODE24 = 1) or 8'h12 (MODE24 = 0). Edge-detect registers are cleared to 0. Outputs take these values immediately, with no clock edge needed.
- Edge detect: min_inc_q and hour_inc_q register the previous input level. min_pulse = min_inc & ~min_inc_q; hour_pulse works the same way. An input held high gives exactly one increment. An input already high when reset releases gives one increment at the first ck edge.
- Latency: a command sampled high at ck edge N updates the field at edge N, so the new value is visible after edge N.
- Seconds:
  - If sec_reset = 1: sec <= 00 on every edge, and no minute carry is generated.
  - Else if en1hz = 1: BCD increment; ones 9 -> 0 with tens +1; 59 -> 00 and generates carry_m.
- Minutes:
  - If min_pulse = 1: BCD increment, 59 -> 00, with no carry into hours.
  - Else if carry_m = 1: BCD increment; 59 -> 00 generates carry_h.
  - If both occur in the same cycle, minutes advance exactly once and no hour carry is produced.
- Hours:
  - If hour_pulse = 1 or carry_h = 1: increment once. If both occur together, still increment only once.
  - MODE24 = 1: 09 -> 10, 19 -> 20, 23 -> 00.
  - MODE24 = 0: 09 -> 10, 12 -> 01.
- Manual increments never ripple into higher fields. Seconds never stop except under sec_reset.
- Blanking is combinational:
  - sec_blank = sec_onoff & ~blink
  - min_blank = min_onoff & ~blink
  - hour_blank = hour_onoff & ~blink
  - With no field selected, all blank outputs are 0.
- Invalid BCD values cannot be reached from reset. The field registers have no load port.
- Reset asserted mid-operation overrides every input immediately. Pending edge-detect state is lost.

Test Plan:
- Reset with MODE24 = 1 -> 00:00:00, all blanks 0. Then 60 en1hz pulses -> 00:01:00, and carry occurs exactly at the sec 59 -> 00 pulse.
- Preload via pulses to 23:59:58, then 2 en1hz pulses -> 23:59:59, then 00:00:00.
- Hold min_inc high for 20 cycles starting at min = 59 -> min = 00 after the first edge only; hour unchanged; no further increments until min_inc drops and rises again.
- min = 59, sec = 59, en1hz and min_pulse in the same cycle -> min = 00, sec = 00, hour unchanged.
- sec = 59, sec_reset = 1 and en1hz = 1 in the same cycle -> sec = 00, min unchanged. Hold sec_reset for 5 en1hz pulses -> sec stays 00.
- MODE24 = 0: reset -> hour = 12. Sequence of hour_inc edges -> 01, 02, …, 09, 10, 11, 12, 01.
- min_onoff = 1 with blink toggling 1, 0, 1 -> min_blank = 0, 1, 0; sec_blank and hour_blank stay 0.
- Assert sysreset between ck edges at 12:34:56 -> outputs read 00:00:00 before the next ck edge.

Source files
------------

// File: rtl/clock_time_counter.sv
// BCD hours/minutes/seconds timekeeper with manual set commands and
// per-field blink blanking for the clock display.
module clock_time_counter #(
    parameter bit MODE24 = 1'b1
) (
    input  logic       ck,
    input  logic       sysreset,
    input  logic       en1hz,
    input  logic       blink,
    input  logic       sec_reset,
    input  logic       min_inc,
    input  logic       hour_inc,
    input  logic       sec_onoff,
    input  logic       min_onoff,
    input  logic       hour_onoff,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       sec_blank,
    output logic       min_blank,
    output logic       hour_blank
);

    localparam int unsigned FW = 8;
    localparam logic [FW-1:0] HOUR_RST = MODE24 ? 8'h00 : 8'h12;
    localparam logic [FW-1:0] HOUR_MAX = MODE24 ? 8'h23 : 8'h12;
    localparam logic [FW-1:0] HOUR_WRAP = MODE24 ? 8'h00 : 8'h01;

    logic min_inc_q;
    logic hour_inc_q;
    logic min_pulse;
    logic hour_pulse;
    logic carry_m;
    logic carry_h;
    logic [FW-1:0] sec_nxt;
    logic [FW-1:0] min_nxt;
    logic [FW-1:0] hour_nxt;

    // Two-digit BCD increment without wrap; callers handle field limits.
    function automatic logic [FW-1:0] bcd_inc(input logic [FW-1:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            bcd_inc = {4'(tens + 4'd1), 4'd0};
        end else begin
            bcd_inc = {tens, 4'(ones + 4'd1)};
        end
    endfunction

    assign min_pulse  = min_inc & ~min_inc_q;
    assign hour_pulse = hour_inc & ~hour_inc_q;

    // Field next-state: manual minute increment suppresses the hour carry.
    always_comb begin
        sec_nxt  = sec;
        min_nxt  = min;
        hour_nxt = hour;
        carry_m  = 1'b0;
        carry_h  = 1'b0;

        if (sec_reset) begin
            sec_nxt = 8'h00;
        end else if (en1hz) begin
            if (sec == 8'h59) begin
                sec_nxt = 8'h00;
                carry_m = 1'b1;
            end else begin
                sec_nxt = bcd_inc(sec);
            end
        end

        if (min_pulse) begin
            min_nxt = (min == 8'h59) ? 8'h00 : bcd_inc(min);
        end else if (carry_m) begin
            if (min == 8'h59) begin
                min_nxt = 8'h00;
                carry_h = 1'b1;
            end else begin
                min_nxt = bcd_inc(min);
            end
        end

        if (hour_pulse || carry_h) begin
            hour_nxt = (hour == HOUR_MAX) ? HOUR_WRAP : bcd_inc(hour);
        end
    end

    always_ff @(posedge ck or posedge sysreset) begin
        if (sysreset) begin
            sec        <= 8'h00;
            min        <= 8'h00;
            hour       <= HOUR_RST;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
        end else begin
            sec        <= sec_nxt;
            min        <= min_nxt;
            hour       <= hour_nxt;
            min_inc_q  <= min_inc;
            hour_inc_q <= hour_inc;
        end
    end

    assign sec_blank  = sec_onoff & ~blink;
    assign min_blank  = min_onoff & ~blink;
    assign hour_blank = hour_onoff & ~blink;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter in 24- and 12-hour modes.
module tb_clock_time_counter;

    logic ck = 1'b0;
    logic sysreset;
    logic en1hz, blink, sec_reset, min_inc, hour_inc;
    logic sec_onoff, min_onoff, hour_onoff;
    logic [7:0] s24, m24, h24, s12, m12, h12;
    logic sb24, mb24, hb24, sb12, mb12, hb12;

    int checks = 0;
    int failures = 0;

    clock_time_counter #(.MODE24(1'b1)) dut24 (
        .ck(ck), .sysreset(sysreset), .en1hz(en1hz), .blink(blink),
        .sec_reset(sec_reset), .min_inc(min_inc), .hour_inc(hour_inc),
        .sec_onoff(sec_onoff), .min_onoff(min_onoff), .hour_onoff(hour_onoff),
        .sec(s24), .min(m24), .hour(h24),
        .sec_blank(sb24), .min_blank(mb24), .hour_blank(hb24)
    );

    clock_time_counter #(.MODE24(1'b0)) dut12 (
        .ck(ck), .sysreset(sysreset), .en1hz(en1hz), .blink(blink),
        .sec_reset(sec_reset), .min_inc(min_inc), .hour_inc(hour_inc),
        .sec_onoff(sec_onoff), .min_onoff(min_onoff), .hour_onoff(hour_onoff),
        .sec(s12), .min(m12), .hour(h12),
        .sec_blank(sb12), .min_blank(mb12), .hour_blank(hb12)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        @(negedge ck);
        en1hz = 0; sec_reset = 0; min_inc = 0; hour_inc = 0;
        sysreset = 1;
        #1;
        sysreset = 0;
    endtask

    task automatic pulse_sec(input int n);
        repeat (n) begin
            en1hz = 1; step(); en1hz = 0; step();
        end
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            min_inc = 1; step(); min_inc = 0; step();
        end
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin
            hour_inc = 1; step(); hour_inc = 0; step();
        end
    endtask

    logic [7:0] h12_seq [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h01};

    initial begin
        sysreset = 1; en1hz = 0; blink = 1; sec_reset = 0; min_inc = 0; hour_inc = 0;
        sec_onoff = 0; min_onoff = 0; hour_onoff = 0;
        #2;
        check("rst_sec", s24, 8'h00);
        check("rst_min", m24, 8'h00);
        check("rst_hour24", h24, 8'h00);
        check("rst_hour12", h12, 8'h12);
        check("rst_blanks", {5'd0, sb24, mb24, hb24}, 8'h00);
        step();
        sysreset = 0;

        // 60 seconds: minute carry exactly on the 59 -> 00 pulse
        pulse_sec(59);
        check("s59_sec", s24, 8'h59);
        check("s59_min", m24, 8'h00);
        pulse_sec(1);
        check("s60_sec", s24, 8'h00);
        check("s60_min", m24, 8'h01);

        // preload 23:59:58 then roll over the day
        do_reset();
        pulse_hour(9);
        check("h24_09", h24, 8'h09);
        pulse_hour(1);
        check("h24_10", h24, 8'h10);
        pulse_hour(10);
        check("h24_20", h24, 8'h20);
        pulse_hour(3);
        pulse_min(59);
        pulse_sec(58);
        check("pre_hour", h24, 8'h23);
        check("pre_min", m24, 8'h59);
        check("pre_sec", s24, 8'h58);
        pulse_sec(1);
        check("d59_sec", s24, 8'h59);
        check("d59_hour", h24, 8'h23);
        pulse_sec(1);
        check("day_sec", s24, 8'h00);
        check("day_min", m24, 8'h00);
        check("day_hour", h24, 8'h00);

        // held min_inc gives one increment; no ripple to hours
        do_reset();
        pulse_min(59);
        min_inc = 1;
        step();
        check("hold_first", m24, 8'h00);
        repeat (19) step();
        check("hold_min", m24, 8'h00);
        check("hold_hour", h24, 8'h00);
        min_inc = 0; step();
        min_inc = 1; step();
        check("hold_rerise", m24, 8'h01);
        min_inc = 0; step();

        // manual minute and seconds carry in the same cycle
        do_reset();
        pulse_min(59);
        pulse_sec(59);
        en1hz = 1; min_inc = 1;
        step();
        en1hz = 0; min_inc = 0;
        check("both_min", m24, 8'h00);
        check("both_sec", s24, 8'h00);
        check("both_hour", h24, 8'h00);

        // sec_reset wins over en1hz and suppresses the carry
        do_reset();
        pulse_sec(59);
        sec_reset = 1; en1hz = 1;
        step();
        en1hz = 0;
        check("sr_sec", s24, 8'h00);
        check("sr_min", m24, 8'h00);
        pulse_sec(5);
        check("sr_hold", s24, 8'h00);
        sec_reset = 0;
        pulse_sec(1);
        check("sr_release", s24, 8'h01);

        // 12-hour sequence from reset value 12
        do_reset();
        check("h12_rst", h12, 8'h12);
        for (int k = 0; k < 13; k++) begin
            pulse_hour(1);
            check($sformatf("h12_seq%0d", k), h12, h12_seq[k]);
        end
        check("h24_13", h24, 8'h13);

        // blanking follows blink on the selected field only
        min_onoff = 1;
        blink = 1; #1;
        check("blk1", {5'd0, sb24, mb24, hb24}, 8'h00);
        blink = 0; #1;
        check("blk0", {5'd0, sb24, mb24, hb24}, 8'h02);
        check("blk0_12", {5'd0, sb12, mb12, hb12}, 8'h02);
        blink = 1; #1;
        check("blk1b", {5'd0, sb24, mb24, hb24}, 8'h00);
        min_onoff = 0; sec_onoff = 1; hour_onoff = 1; blink = 0; #1;
        check("blk_sh", {5'd0, sb24, mb24, hb24}, 8'h05);
        sec_onoff = 0; hour_onoff = 0; blink = 1;

        // async reset between edges at 12:34:56
        do_reset();
        pulse_hour(12);
        pulse_min(34);
        pulse_sec(56);
        check("pre_async", {h24}, 8'h12);
        @(negedge ck);
        sysreset = 1;
        #1;
        check("async_sec", s24, 8'h00);
        check("async_min", m24, 8'h00);
        check("async_hour24", h24, 8'h00);
        check("async_hour12", h12, 8'h12);
        sysreset = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
